// File: rtl/ans_ht_stf_pkg.sv
// Shared defaults and write-side state encoding for the HT-STF sink.
package ans_ht_stf_pkg;

    localparam int FRAME_LEN_DEF = 80;
    localparam int DEPTH_DEF     = 128;
    localparam int DW_DEF        = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/ans_sync_fifo.sv
// Single-clock FIFO with a registered head word and full/empty/count.
module ans_sync_fifo #(
    parameter int DEPTH = 128,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW:0]   next_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_n;
    logic          wr_ok;
    logic          rd_ok;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign rptr_n = rd_ok ? rptr + AW'(1) : rptr;

    always_comb begin
        next_count = count;
        if (wr_ok && !rd_ok) begin
            next_count = count + (AW+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            next_count = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    // Head register tracks the word at rptr_n; a write into an
    // otherwise-empty queue lands here directly from wr_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            rptr  <= rptr_n;
            count <= next_count;
            if (next_count != '0) begin
                if (wr_ok && next_count == (AW+1)'(1)) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rptr_n];
                end
            end
        end
    end

endmodule

// File: rtl/ans_ht_stf_sink.sv
// Captures HT-STF frames from the generator and replays them as a stream.
module ans_ht_stf_sink
    import ans_ht_stf_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stf_started,
    input  logic [DW-1:0] stf_sample,
    output logic          stf_givemeoutput,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          frame_done,
    output logic          overflow_err,
    output logic          protocol_err,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [AW:0] GIVE_MAX = (AW+1)'(DEPTH - FRAME_LEN);

    wr_state_e     state;
    wr_state_e     state_n;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_n;
    logic [CW-1:0] rcnt;
    logic          wr_en;
    logic          xfer;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW:0]   next_count;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        wr_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (stf_started) begin
                    wr_en   = 1'b1;
                    state_n = (FRAME_LEN > 1) ? CAPTURE : IDLE;
                    wcnt_n  = (FRAME_LEN > 1) ? CW'(1) : '0;
                end
            end
            CAPTURE: begin
                wr_en = 1'b1;
                if (wcnt == LAST) begin
                    wcnt_n  = '0;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m_tvalid = !empty;
    assign m_tlast  = m_tvalid && (rcnt == LAST);
    assign xfer     = m_tvalid && m_tready;
    assign busy     = (state == CAPTURE) || !empty;

    ans_sync_fifo #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (stf_sample),
        .rd_en     (m_tready),
        .rd_data   (m_tdata),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .next_count(next_count)
    );

    // Permission is computed from next-cycle state so it never
    // lingers high on the cycle capture begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wcnt             <= '0;
            rcnt             <= '0;
            frame_done       <= 1'b0;
            overflow_err     <= 1'b0;
            protocol_err     <= 1'b0;
            stf_givemeoutput <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (xfer) begin
                rcnt <= m_tlast ? '0 : rcnt + CW'(1);
            end
            frame_done <= xfer && m_tlast;
            if (wr_en && full) begin
                overflow_err <= 1'b1;
            end
            if (state == CAPTURE && stf_started) begin
                protocol_err <= 1'b1;
            end
            stf_givemeoutput <= (state_n == IDLE) &&
                                (next_count <= GIVE_MAX);
        end
    end

endmodule
